stopwatch_controller: RTL
=========================

// Module: stopwatch_controller
// PURPOSE
//  Control FSM that sequences the 4-digit MM:SS BCD counter chain (count up / count down).
//  Turns debounced 1-cycle button pulses into counter controls:
//   - run enable, direction, preset load
//  Also provides a lap freeze and an expiry alarm. Sits between the button debouncers and
//  the counter chain, and drives the display mux.
// PARAMETERS
//  BOARD_CLOCK_FREQUENCY_IN_HZ  100_000_000  clk frequency
//  TICK_FREQUENCY_IN_HZ         1            count tick rate; TICK_DIV = BOARD/TICK, must be >= 2
//  NUMBER_OF_DIGITS             4            BCD digits (MM:SS)
//  NUMBER_OF_BITS_PER_DIGIT     4            bits per digit; NB = DIGITS*BITS
// PORTS
//  clk            in   1   system clock
//  rst            in   1   reset, asynchronous, active-low
//  btn_start_stop in   1   1-cycle pulse: start/pause/acknowledge
//  btn_lap        in   1   1-cycle pulse: lap freeze/release
//  btn_clear      in   1   1-cycle pulse: reload counter
//  up_down_sel    in   1   direction request: 1=up, 0=down; sampled only in IDLE
//  preset_value   in   NB  BCD countdown start value (MM:SS)
//  count_value    in   NB  live BCD value from the counter chain
//  count_tick     out  1   1-cycle enable pulse to the seconds-1 counter
//  count_up_down  out  1   latched direction to the counter chain
//  count_load     out  1   1-cycle load strobe to the counter chain
//  load_value     out  NB  value loaded on count_load
//  display_value  out  NB  count_value, or lap_value while lap_active
//  lap_active     out  1   display frozen on lap_value
//  alarm          out  1   high in EXPIRED
//  state          out  2   current FSM state (debug/LED)
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset values:
//   - state=IDLE, count_up_down=1, all strobes 0, lap_active=0, alarm=0
//   - lap_value=0, load_value=0, prescaler=0
//  Terminal value TERM:
//   - up mode: 5959 (BCD 16'h5959)
//   - down mode: 0000
//  Button priority in one cycle: clear > start_stop > lap; lower-priority pulses are dropped.
//  IDLE:
//   - count_up_down <= up_down_sel every cycle
//   - clear: count_load=1 for 1 cycle; load_value = preset_value if down mode, else 0
//   - start_stop: go to RUNNING if count_value != TERM; ignored otherwise
//  RUNNING:
//   - prescaler counts 0..TICK_DIV-1; count_tick=1 on the cycle it wraps
//   - first tick comes exactly TICK_DIV cycles after entering RUNNING
//   - if count_value == TERM: go to EXPIRED next cycle, no tick issued (saturate, never wrap)
//   - start_stop: go to PAUSED; prescaler holds its value (resumes mid-period)
//   - lap: toggle lap_active; on rising toggle, lap_value <= count_value
//   - clear: ignored
//  PAUSED:
//   - no ticks
//   - start_stop: return to RUNNING
//   - clear: count_load as in IDLE, prescaler=0, lap_active=0, go to IDLE
//   - lap: clears lap_active
//  EXPIRED:
//   - alarm=1, no ticks
//   - start_stop or clear: count_load as in IDLE, alarm=0, prescaler=0, lap_active=0, go to IDLE
//  Tick vs TERM in the same cycle: TERM check wins, so the value never steps past TERM.
//  Latency:
//   - button to state change: 1 cycle
//   - count_load asserted the cycle after the button pulse
//  Direction is frozen outside IDLE.
//  Reset mid-run: immediate IDLE; counter values are untouched (the counter has its own reset).
// STRUCTURE
//  stopwatch_pkg holds:
//   - state encoding: IDLE=0, RUNNING=1, PAUSED=2, EXPIRED=3
//   - TERM_UP=16'h5959, TERM_DOWN=16'h0000
//   - TICK_DIV computation function
//  Sub-module tick_prescaler (ports: clk, rst, run, clear, tick) holds the divider counter.
//  All other logic (FSM, lap register, outputs) lives in this module.
// TESTING (BOARD=10, TICK=1 -> TICK_DIV=10)
//  1. Reset low mid-RUNNING -> state=0, alarm=0, lap_active=0, count_tick=0 immediately.
//  2. Up mode, start at count 0000 -> count_tick pulses at cycles 10, 20, 30; start_stop at 25
//     -> PAUSED, no tick; resume -> next tick 5 cycles later.
//  3. Down mode, preset 0003, clear -> count_load=1, load_value=0003; start
//     -> 3 ticks, count 0000 -> EXPIRED, alarm=1, no further ticks.
//  4. Up mode, count 5959 in RUNNING -> EXPIRED next cycle, no tick; clear
//     -> load_value=0000, IDLE.
//  5. Lap at count 0012 -> lap_active=1, display_value=0012 while the count advances;
//     lap again -> display follows the live count.
//  6. clear+start_stop in the same cycle in PAUSED -> IDLE with load; start_stop in IDLE
//     with down-mode count 0000 -> stays IDLE.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared encodings and constants for the stopwatch controller and its prescaler.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_PAUSED   = 2'd2,
        ST_EXPIRED  = 2'd3
    } sw_state_e;

    localparam logic [15:0] TERM_UP   = 16'h5959;
    localparam logic [15:0] TERM_DOWN = 16'h0000;

    function automatic int unsigned calc_tick_div(input int unsigned board_hz,
                                                  input int unsigned tick_hz);
        return board_hz / tick_hz;
    endfunction

endpackage

// File: rtl/stopwatch_controller_tick_prescaler.sv
// Divider that emits a one-cycle tick every TICK_DIV enabled cycles; holds its count while idle.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                tick_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/stopwatch_controller.sv
// Button-driven control FSM for an MM:SS BCD stopwatch chain: run/pause, direction,
// preset reload, lap freeze and expiry alarm.
//   state    | meaning
//   IDLE     | stopped; direction follows up_down_sel, clear reloads the counter
//   RUNNING  | prescaler enabled, ticks sent to the counter chain
//   PAUSED   | ticks held, prescaler keeps its phase
//   EXPIRED  | counter reached its terminal value; alarm raised until acknowledged
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int unsigned TICK_FREQUENCY_IN_HZ        = 1,
    parameter int unsigned NUMBER_OF_DIGITS            = 4,
    parameter int unsigned NUMBER_OF_BITS_PER_DIGIT    = 4,
    localparam int unsigned NB = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          btn_start_stop_i,
    input  logic          btn_lap_i,
    input  logic          btn_clear_i,
    input  logic          up_down_sel_i,
    input  logic [NB-1:0] preset_value_i,
    input  logic [NB-1:0] count_value_i,
    output logic          count_tick_o,
    output logic          count_up_down_o,
    output logic          count_load_o,
    output logic [NB-1:0] load_value_o,
    output logic [NB-1:0] display_value_o,
    output logic          lap_active_o,
    output logic          alarm_o,
    output logic [1:0]    state_o
);

    localparam int unsigned TICK_DIV =
        calc_tick_div(BOARD_CLOCK_FREQUENCY_IN_HZ, TICK_FREQUENCY_IN_HZ);
    localparam logic [NB-1:0] TERM_UP_V   = NB'(TERM_UP);
    localparam logic [NB-1:0] TERM_DOWN_V = NB'(TERM_DOWN);

    sw_state_e     state_q, state_d;
    logic          dir_q, dir_d;
    logic          load_q, load_d;
    logic [NB-1:0] load_val_q, load_val_d;
    logic          lap_act_q, lap_act_d;
    logic [NB-1:0] lap_val_q, lap_val_d;

    logic          ss, lap, clr;
    logic          at_term;
    logic [NB-1:0] reload_val;
    logic          pre_run, pre_clear, pre_tick;

    // Only the highest-priority button of a cycle is acted on.
    assign clr = btn_clear_i;
    assign ss  = btn_start_stop_i & ~btn_clear_i;
    assign lap = btn_lap_i & ~btn_start_stop_i & ~btn_clear_i;

    assign at_term    = (count_value_i == (dir_q ? TERM_UP_V : TERM_DOWN_V));
    assign reload_val = dir_q ? '0 : preset_value_i;

    // Holding the prescaler at TERM keeps a tick from stepping the value past it.
    assign pre_run = (state_q == ST_RUNNING) && !at_term;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .run_i  (pre_run),
        .clear_i(pre_clear),
        .tick_o (pre_tick)
    );

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        load_d     = 1'b0;
        load_val_d = load_val_q;
        lap_act_d  = lap_act_q;
        lap_val_d  = lap_val_q;
        pre_clear  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                dir_d = up_down_sel_i;
                if (clr) begin
                    load_d     = 1'b1;
                    load_val_d = reload_val;
                end else if (ss && !at_term) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (at_term) begin
                    state_d = ST_EXPIRED;
                end else if (ss) begin
                    state_d = ST_PAUSED;
                end else if (lap) begin
                    lap_act_d = ~lap_act_q;
                    if (!lap_act_q) lap_val_d = count_value_i;
                end
            end
            ST_PAUSED: begin
                if (clr) begin
                    load_d     = 1'b1;
                    load_val_d = reload_val;
                    pre_clear  = 1'b1;
                    lap_act_d  = 1'b0;
                    state_d    = ST_IDLE;
                end else if (ss) begin
                    state_d = ST_RUNNING;
                end else if (lap) begin
                    lap_act_d = 1'b0;
                end
            end
            ST_EXPIRED: begin
                if (clr || ss) begin
                    load_d     = 1'b1;
                    load_val_d = reload_val;
                    pre_clear  = 1'b1;
                    lap_act_d  = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            dir_q      <= 1'b1;
            load_q     <= 1'b0;
            load_val_q <= '0;
            lap_act_q  <= 1'b0;
            lap_val_q  <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            load_q     <= load_d;
            load_val_q <= load_val_d;
            lap_act_q  <= lap_act_d;
            lap_val_q  <= lap_val_d;
        end
    end

    assign count_tick_o    = pre_tick;
    assign count_up_down_o = dir_q;
    assign count_load_o    = load_q;
    assign load_value_o    = load_val_q;
    assign display_value_o = lap_act_q ? lap_val_q : count_value_i;
    assign lap_active_o    = lap_act_q;
    assign alarm_o         = (state_q == ST_EXPIRED);
    assign state_o         = state_q;

endmodule
